// File: rtl/vga_timing_counter.sv
// One axis of VGA timing: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracking.
// Instances cascade through terminal (horizontal terminal drives vertical enable).
module vga_timing_counter #(
    parameter int unsigned ACTIVE      = 640,
    parameter int unsigned FRONT_PORCH = 16,
    parameter int unsigned SYNC_PULSE  = 96,
    parameter int unsigned BACK_PORCH  = 48,
    parameter bit          SYNC_POL    = 1'b0,
    localparam int unsigned TOTAL      = ACTIVE + FRONT_PORCH + SYNC_PULSE + BACK_PORCH,
    localparam int unsigned W          = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic [1:0]   phase,
    output logic         sync,
    output logic         display_active,
    output logic         terminal
);

    localparam int unsigned SYNC_START = ACTIVE + FRONT_PORCH;
    localparam int unsigned BACK_START = SYNC_START + SYNC_PULSE;

    localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE - 1);
    localparam logic [W-1:0] LAST_FRONT  = W'(SYNC_START - 1);
    localparam logic [W-1:0] LAST_SYNC   = W'(BACK_START - 1);
    localparam logic [W-1:0] LAST_POS    = W'(TOTAL - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    logic [W-1:0] count_q, count_d;
    phase_e       phase_q, phase_d;
    logic         sync_q;
    logic         disp_q;
    logic         at_last;

    assign at_last = (count_q == LAST_POS);

    // Next position and next phase; each phase exits on its own last position so
    // the phase changes on the same edge the count crosses the boundary.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (clear) begin
            count_d = '0;
            phase_d = PH_ACTIVE;
        end else if (enable) begin
            count_d = at_last ? '0 : count_q + W'(1);
            unique case (phase_q)
                PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = PH_FRONT;
                PH_FRONT:  if (count_q == LAST_FRONT)  phase_d = PH_SYNC;
                PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = PH_BACK;
                PH_BACK:   if (at_last)                phase_d = PH_ACTIVE;
                default:                               phase_d = PH_ACTIVE;
            endcase
        end
    end

    // Registered state; sync and display_active are decoded from the next phase
    // so they stay aligned with phase every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
            sync_q  <= ~SYNC_POL;
            disp_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            sync_q  <= (phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            disp_q  <= (phase_d == PH_ACTIVE);
        end
    end

    assign count          = count_q;
    assign phase          = phase_q;
    assign sync           = sync_q;
    assign display_active = disp_q;
    assign terminal       = enable & ~clear & at_last;

endmodule

// File: tb/tb_vga_timing_counter.sv
// Bench for vga_timing_counter: small H/V cascade plus a default-sized free-running instance.
module tb_vga_timing_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;

    logic [3:0] h_count, v_count;
    logic [1:0] h_phase, v_phase;
    logic       h_sync, v_sync, h_disp, v_disp, h_term, v_term;

    logic [9:0] d_count;
    logic [1:0] d_phase;
    logic       d_sync, d_disp, d_term;

    always #5 clk = ~clk;

    vga_timing_counter #(.ACTIVE(4), .FRONT_PORCH(2), .SYNC_PULSE(3), .BACK_PORCH(1), .SYNC_POL(1'b0)) u_h (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .count(h_count), .phase(h_phase), .sync(h_sync),
        .display_active(h_disp), .terminal(h_term));

    vga_timing_counter #(.ACTIVE(4), .FRONT_PORCH(2), .SYNC_PULSE(3), .BACK_PORCH(1), .SYNC_POL(1'b0)) u_v (
        .clk(clk), .rst_n(rst_n), .enable(h_term), .clear(1'b0),
        .count(v_count), .phase(v_phase), .sync(v_sync),
        .display_active(v_disp), .terminal(v_term));

    vga_timing_counter u_d (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .clear(1'b0),
        .count(d_count), .phase(d_phase), .sync(d_sync),
        .display_active(d_disp), .terminal(d_term));

    typedef struct {
        int hc; int hp; bit hs; bit hd; bit ht;
        int vc; int vp; bit vt;
        int dc; int dp; bit ds; bit dd; bit dt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: plain positions; phase derived from interval arithmetic.
    int   m_h = 0, m_v = 0, m_d = 0;
    bit   meas = 1'b0;
    int   low_cnt = 0;

    function automatic int ph_of(int c, int a, int f, int s);
        if (c < a)         return 0;
        if (c < a + f)     return 1;
        if (c < a + f + s) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, publish expectations, advance model.
    task automatic step(input bit en, input bit clr, input bit rn);
        exp_t e;
        bit   ht, vt, dt;
        @(negedge clk);
        rst_n  = rn;
        enable = en;
        clear  = clr;
        if (!rn) begin
            m_h = 0; m_v = 0; m_d = 0;
        end
        #1;
        ht = en && !clr && (m_h == 9);
        vt = ht && (m_v == 9);
        dt = (m_d == 799);
        e.hc = m_h; e.hp = ph_of(m_h, 4, 2, 3); e.hs = (e.hp != 2); e.hd = (e.hp == 0); e.ht = ht;
        e.vc = m_v; e.vp = ph_of(m_v, 4, 2, 3); e.vt = vt;
        e.dc = m_d; e.dp = ph_of(m_d, 640, 16, 96); e.ds = (e.dp != 2); e.dd = (e.dp == 0); e.dt = dt;
        q.push_back(e);
        if (meas && !d_sync) low_cnt++;
        if (rn) begin
            if (clr)     m_h = 0;
            else if (en) m_h = (m_h + 1) % 10;
            if (ht) m_v = (m_v + 1) % 10;
            m_d = (m_d + 1) % 800;
        end
    endtask

    // Monitor: every cycle the design presents a full output set; compare with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("h_count", int'(h_count), e.hc);
                chk("h_phase", int'(h_phase), e.hp);
                chk("h_sync", int'(h_sync), int'(e.hs));
                chk("h_display_active", int'(h_disp), int'(e.hd));
                chk("h_terminal", int'(h_term), int'(e.ht));
                chk("v_count", int'(v_count), e.vc);
                chk("v_phase", int'(v_phase), e.vp);
                chk("v_terminal", int'(v_term), int'(e.vt));
                chk("d_count", int'(d_count), e.dc);
                chk("d_phase", int'(d_phase), e.dp);
                chk("d_sync", int'(d_sync), int'(e.ds));
                chk("d_display_active", int'(d_disp), int'(e.dd));
                chk("d_terminal", int'(d_term), int'(e.dt));
            end
        end
    end

    initial begin
        int guard;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        // Free run across a wrap
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);
        // Enable toggling, passing count 9 with both enable levels
        for (int i = 0; i < 24; i++) step(1'(i % 2 == 0), 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) step(1'(i % 2 == 1), 1'b0, 1'b1);
        // Clear with enable at count 7
        guard = 0;
        while (m_h != 7 && guard < 20) begin step(1'b1, 1'b0, 1'b1); guard++; end
        chk("reach_count7", m_h, 7);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        // Asynchronous reset between edges at count 5
        guard = 0;
        while (m_h != 5 && guard < 20) begin step(1'b1, 1'b0, 1'b1); guard++; end
        chk("reach_count5", m_h, 5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        // Long continuous run to exercise the H->V cascade through full V frames
        for (int i = 0; i < 220; i++) step(1'b1, 1'b0, 1'b1);
        // Randomised enable/clear/reset
        for (int i = 0; i < 1500; i++)
            step(1'($urandom % 4 != 0), 1'($urandom % 16 == 0), 1'($urandom % 64 != 0));
        // Count sync-low cycles of the default instance over exactly one 800-cycle window
        meas = 1'b1;
        for (int i = 0; i < 800; i++) step(1'($urandom % 2), 1'b0, 1'b1);
        meas = 1'b0;
        chk("d_sync_low_per_frame", low_cnt, 96);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
